// File: rtl/dac_sched.sv
// dac_sched: round-robin scheduler sharing one DAC serializer among NREQ
// sample producers.
//
// Flow: IDLE picks a winner among the valid requesters (only while the
// serializer reports not busy), accepts its word with a one-hot ready, then
// LAUNCH pulses dac_start for one cycle.  WAIT_ACK waits up to ACK_TO cycles
// for dac_busy to rise; if it never rises the word is dropped and the sticky
// err flag is set.  WAIT_DONE waits for dac_busy to fall.  GAP idles for GAP
// cycles, or is skipped when GAP is 0, before returning to IDLE.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]     requester i has a word
//   req_data   [NREQ*DW]  word of requester i at [i*DW +: DW]
//   req_ready  [NREQ]     one-hot accept, combinational in IDLE
//   dac_start  one-cycle frame launch pulse
//   dac_data   [DW]       word for the serializer, held until the next grant
//   dac_busy   serializer frame in progress
//   grant_id   index of the last granted requester
//   active     high whenever the scheduler is not in IDLE
//   err        sticky ack-timeout flag, cleared only by reset
//
// Configuration macro: DAC_SCHED_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest valid index wins, pointer held at 0
//   undefined -> round-robin starting at the rotate pointer
module dac_sched #(
  parameter int NREQ   = 4,
  parameter int DW     = 12,
  parameter int GAP    = 8,
  parameter int ACK_TO = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     dac_start,
  output logic [DW-1:0]            dac_data,
  input  logic                     dac_busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     active,
  output logic                     err
);

  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (ACK_TO > GAP) ? ACK_TO : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TO - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   winner;
  logic            found;
  logic            grant;

  // Search from the rotate pointer, wrapping modulo NREQ.  In fixed-priority
  // builds the pointer is held at 0, so the same search yields lowest index.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  // Gating with rst_n keeps ready low while reset is held even though the
  // state register already reads IDLE.
  assign grant = rst_n && (state == S_IDLE) && found && !dac_busy;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  // Single state machine; all outputs other than req_ready are registered
  // so they change together with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      dac_start <= 1'b0;
      dac_data  <= '0;
      grant_id  <= '0;
      active    <= 1'b0;
      err       <= 1'b0;
    end else begin
      dac_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            dac_data  <= req_data[int'(winner)*DW +: DW];
            grant_id  <= winner;
`ifdef DAC_SCHED_FIXED_PRIO_EN
            ptr       <= '0;
`else
            ptr       <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
`endif
            dac_start <= 1'b1;
            active    <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // Only a high level of dac_busy counts; a low glitch is just
          // another cycle of waiting.
          if (dac_busy) begin
            state <= S_WAIT_DONE;
          end else if (cnt == ACK_LAST) begin
            err <= 1'b1;
            if (GAP == 0) begin
              state  <= S_IDLE;
              active <= 1'b0;
            end else begin
              cnt   <= '0;
              state <= S_GAP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!dac_busy) begin
            if (GAP == 0) begin
              state  <= S_IDLE;
              active <= 1'b0;
            end else begin
              cnt   <= '0;
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state  <= S_IDLE;
            active <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dac_sched.md
# dac_sched

Round-robin scheduler sharing the single 12-bit DAC serializer among up to NREQ sample producers. Each requester offers a word over a valid/ready handshake. The block grants one requester, launches one serializer frame with a start pulse, and tracks the serializer busy flag until the frame completes. It then enforces a minimum inter-frame gap and re-arbitrates. It sits between the per-channel sample generators and the serializer that drives SCLK/SYNCn/DIN.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 12, sample width
- GAP, 8, idle cycles after frame completion before next grant (0 allowed)
- ACK_TO, 15, cycles to wait for Dac_busy rise after start before abort
- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  asynchronous, active-low reset
- Req_valid  in  NREQ  requester i has a word
- Req_data  in  NREQ*DW  word of requester i at bits [i*DW +: DW]
- Req_ready  out  NREQ  one-hot accept; transfer when valid&ready
- Dac_start  out  1  one-cycle frame launch pulse to serializer
- Dac_data  out  DW  word for serializer, stable from start until frame done
- Dac_busy  in  1  serializer frame in progress
- Grant_id  out  $clog2(NREQ)  index of last granted requester
- Active  out  1  high in any state except IDLE
- Err  out  1  sticky: ack timeout occurred; cleared only by reset

## Operation
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, GAP.
- IDLE: if any Req_valid and Dac_busy=0, pick winner, assert Req_ready[winner] combinationally, capture Req_data slice into Dac_data, load Grant_id, go LAUNCH. Otherwise Req_ready=0.
- Arbitration: search starts at rotate pointer p. First valid index (p, p+1, ... wrapping mod NREQ) wins. After grant to i, p <= (i+1) mod NREQ.
- LAUNCH: Dac_start=1 for exactly one cycle, then WAIT_ACK with timeout counter cleared.
- WAIT_ACK: Dac_busy=1 -> WAIT_DONE. If the counter reaches ACK_TO without busy, set Err and go GAP; the word is dropped and not retried.
- WAIT_DONE: Dac_busy=0 -> GAP.
- GAP: count GAP cycles, then IDLE. With GAP=0, go straight to IDLE.
- Requester rule: Req_data must hold while Req_valid=1 and Req_ready=0. Deasserting valid before grant withdraws the request with no side effect.
- Dac_busy high while in IDLE (serializer not idle): no grant until it falls.

## Timing
- Reset values: Req_ready=0, Dac_start=0, Dac_data=0, Grant_id=0, Active=0, Err=0, p=0, state IDLE, counters 0.
- Grant-to-start latency: handshake in cycle N gives Dac_start=1 in cycle N+1.
- Minimum request-to-request spacing: 1 (grant) + 1 (launch) + ack wait + frame + GAP cycles.
- Simultaneous valids: exactly one Req_ready bit set per grant cycle; never more than one.
- Reset mid-operation (any state): outputs return to reset values immediately and asynchronously. An in-flight frame is abandoned, and the serializer must be reset by the same Rst.
- Dac_busy glitch falling in WAIT_ACK before rising: ignored; only the rise is sampled.

## Configuration
- DAC_SCHED_FIXED_PRIO_EN defined: arbitration is fixed priority. The lowest index valid requester always wins, and p is unused and held at 0.
- Undefined (default): round-robin as described above.

## Test plan
- Single requester 0, data 12'hC93, Dac_busy model rising 2 cycles after start and held 34 cycles -> Req_ready[0] one cycle, Dac_start one cycle later, Dac_data=12'hC93 throughout busy, next grant no earlier than GAP=8 cycles after busy falls.
- Requesters 0,1,2 all valid continuously with data 12'h895/12'h589/12'h001 -> grants in order 0,1,2,0,1,2. Grant_id matches each grant, and only one Req_ready bit is high per grant.
- DAC_SCHED_FIXED_PRIO_EN defined, requesters 1 and 3 valid continuously -> every grant goes to 1. Grants go to 3 only after valid[1] drops.
- Serializer model never raises busy -> Err=1 after ACK_TO=15 cycles in WAIT_ACK, then GAP, then IDLE. The next request is still served and Err stays 1.
- Rst low for 3 cycles during WAIT_DONE -> all outputs at reset values during reset. After release, a pending requester 2 is granted first search from p=0 (with 0 and 1 idle) and gets Req_ready[2].
- Dac_busy held high at reset release with requester 0 valid -> no Req_ready until busy falls. The grant occurs in the first cycle busy is low.
